fsm_sym_track: RTL and testbench
================================

Name: fsm_sym_track

Overview:
- Parametrised successor to the 2-input "state follows input" FSM.
- Tracks a W-bit input symbol and holds it as the current state.
- A new symbol is accepted only after it is held stable for STABLE consecutive enabled cycles (glitch rejection).
- Also reports the previous state, a one-cycle change pulse, and a saturating dwell count. Sits between raw control inputs and downstream mode logic.

Parameters:
- W, 2, symbol/state width in bits (W >= 1).
- STABLE, 1, consecutive enabled samples required to accept a new symbol (>= 1). A value of 1 gives the legacy one-edge latency.
- DW, 8, dwell counter width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample enable. When low, all state holds.
- sym_in  in  W  raw input symbol.
- state  out  W  accepted (qualified) symbol.
- prev_state  out  W  symbol accepted before the current one.
- state_vld  out  1  high once any symbol has been accepted since reset.
- chg_pulse  out  1  one-cycle pulse on each accepted change.
- dwell  out  DW  enabled cycles spent in the current state, saturating.
- dwell_sat  out  1  high while dwell equals 2^DW-1.

Behaviour:
- Reset (async, rst=1), all outputs 0:
  - state=0, prev_state=0, state_vld=0, chg_pulse=0, dwell=0, dwell_sat=0.
  - Internal: ctl=INIT, cand=0, qcnt=0.
- All outputs are registered. chg_pulse is cleared on every edge where no accept occurs.
- en=0: every register holds, except chg_pulse, which clears.
- Control FSM (ctl):
  - INIT: no symbol accepted yet. Every sample is qualified against cand.
  - TRACK: state valid and sym_in==state.
  - QUAL: state valid, sym_in!=state, candidate under qualification.
- Qualification, per enabled edge:
  - k = count of consecutive samples equal to cand, including the current one.
  - If sym_in==cand, k=qcnt+1. Otherwise cand<=sym_in and k=1.
  - If k==STABLE: accept.
  - Else: qcnt<=k, ctl<=QUAL (stays INIT if no valid state yet).
- In QUAL, if sym_in==state: abort. ctl<=TRACK, qcnt<=0; dwell keeps counting (no change is recorded).
- Accept, from INIT or QUAL:
  - state<=sym_in, qcnt<=0, ctl<=TRACK, dwell<=0, dwell_sat<=0.
  - From QUAL: prev_state<=old state, chg_pulse<=1.
  - From INIT: prev_state unchanged, chg_pulse stays 0, state_vld<=1.
- Latency: a new symbol stable from edge n is visible on state after edge n+STABLE-1 (STABLE=1: after the same edge, one cycle after it is applied).
- dwell: increments on each enabled edge while state_vld=1 and no accept occurs. It saturates at 2^DW-1 with no wrap, and dwell_sat=1 while saturated.
- Simultaneous accept and saturation: accept wins (dwell<=0).
- Reset mid-qualification discards cand/qcnt. The next symbol starts from INIT.
- Unused ctl encoding recovers to INIT on the next enabled edge.

Optional Feature:
- Macro FSM_SYM_TRACK_TRANS_CNT_EN.
- When defined: adds output port trans_cnt (16 bits, out) that counts accepted changes (chg_pulse events). It wraps modulo 2^16 and resets to 0.
- When undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package fsm_sym_pkg holds:
  - the ctl state encoding (INIT=2'b00, TRACK=2'b01, QUAL=2'b10);
  - default widths W_DEF=2, DW_DEF=8;
  - the trans_cnt width constant 16.
- One natural sub-module: fsm_sym_qual.
  - Inputs: sym_in, state, state_vld, en.
  - Holds: cand/qcnt qualification counter.
  - Outputs: accept strobe and accepted symbol.
- The top level owns state, prev_state, dwell and the pulse.

Test Plan:
- W=2, STABLE=1: after reset, drive sym_in 00,01,10,11 on successive enabled edges. Required response:
  - state follows one edge later: 00,01,10,11.
  - chg_pulse high on the 2nd, 3rd and 4th accepts only.
  - prev_state sequence 00,01,10.
- STABLE=3, state=01: drive 10 for 2 cycles, then 01. Required: no accept, chg_pulse never high, dwell increments continuously by 3.
- STABLE=3, state=01: drive 10,11,11,11. Required: state=11 after the 4th edge, prev_state=01, a single chg_pulse, dwell=0 on the next cycle.
- DW=4: hold a symbol for 20 enabled cycles. Required: dwell reaches 15 and sticks, dwell_sat=1. Then change the symbol: dwell=0, dwell_sat=0.
- STABLE=2: with en=0 for 5 cycles mid-qualification, sym_in stays at the candidate. Required: registers frozen; accept on the first enabled edge after en returns high.
- Assert rst mid-QUAL. Required: outputs all 0 asynchronously. With FSM_SYM_TRACK_TRANS_CNT_EN defined, trans_cnt=0, then it counts 1 per subsequent change.

Source files
------------

// File: rtl/fsm_sym_pkg.sv
// Shared definitions for the fsm_sym_track block: control-state encoding,
// default widths and the width of the optional transition counter.
package fsm_sym_pkg;

  typedef enum logic [1:0] {
    CTL_INIT  = 2'b00,  // no symbol accepted since reset
    CTL_TRACK = 2'b01,  // state valid, input matches state
    CTL_QUAL  = 2'b10   // state valid, a different candidate is being qualified
  } ctl_e;

  localparam int W_DEF       = 2;
  localparam int DW_DEF      = 8;
  localparam int TRANS_CNT_W = 16;

  // Width needed to hold a qualification count in 0..stable.
  function automatic int qcnt_width(input int stable);
    if (stable < 1) begin
      return 1;
    end else begin
      return $clog2(stable + 1);
    end
  endfunction

endpackage

// File: rtl/fsm_sym_qual.sv
// Glitch-rejection qualifier for fsm_sym_track. Owns the control FSM and the
// candidate/run-length pair; raises a one-cycle accept strobe when the
// candidate has been seen on STABLE consecutive enabled samples.
module fsm_sym_qual
  import fsm_sym_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int STABLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] sym_in,
  input  logic [W-1:0] state,
  input  logic         state_vld,
  output logic         accept,
  output logic [W-1:0] acc_sym
);

  localparam int              QW       = qcnt_width(STABLE);
  localparam logic [QW-1:0]   STABLE_Q = QW'(STABLE);

  ctl_e          ctl_r;
  ctl_e          ctl_nxt_s;
  logic [W-1:0]  cand_r;
  logic [W-1:0]  cand_nxt_s;
  logic [QW-1:0] qcnt_r;
  logic [QW-1:0] qcnt_nxt_s;
  logic [QW-1:0] k_s;
  logic          qualify_s;

  // The accepted symbol is always the sample on the accepting edge.
  assign acc_sym = sym_in;

  // Run length including the current sample: extends the run or restarts at 1.
  always_comb begin
    if (sym_in == cand_r) begin
      k_s = qcnt_r + QW'(1);
    end else begin
      k_s = QW'(1);
    end
  end

  // Next-state logic: decide whether this edge qualifies, aborts or holds.
  always_comb begin
    ctl_nxt_s  = ctl_r;
    cand_nxt_s = cand_r;
    qcnt_nxt_s = qcnt_r;
    accept     = 1'b0;
    qualify_s  = 1'b0;

    if (en) begin
      case (ctl_r)
        CTL_INIT: begin
          qualify_s = 1'b1;
        end
        CTL_TRACK: begin
          if (sym_in != state) begin
            qualify_s = 1'b1;
          end else begin
            ctl_nxt_s = CTL_TRACK;
          end
        end
        CTL_QUAL: begin
          if (sym_in == state) begin
            // Input fell back to the held symbol: drop the candidate run.
            ctl_nxt_s  = CTL_TRACK;
            qcnt_nxt_s = {QW{1'b0}};
          end else begin
            qualify_s = 1'b1;
          end
        end
        default: begin
          // Unused encoding: restart cleanly.
          ctl_nxt_s  = CTL_INIT;
          qcnt_nxt_s = {QW{1'b0}};
        end
      endcase
    end else begin
      ctl_nxt_s = ctl_r;
    end

    if (qualify_s) begin
      cand_nxt_s = sym_in;
      if (k_s == STABLE_Q) begin
        accept     = 1'b1;
        ctl_nxt_s  = CTL_TRACK;
        qcnt_nxt_s = {QW{1'b0}};
      end else begin
        qcnt_nxt_s = k_s;
        ctl_nxt_s  = state_vld ? CTL_QUAL : CTL_INIT;
      end
    end else begin
      accept = 1'b0;
    end
  end

  // Control state, candidate and run-length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_r  <= CTL_INIT;
      cand_r <= {W{1'b0}};
      qcnt_r <= {QW{1'b0}};
    end else begin
      ctl_r  <= ctl_nxt_s;
      cand_r <= cand_nxt_s;
      qcnt_r <= qcnt_nxt_s;
    end
  end

endmodule

// File: rtl/fsm_sym_track.sv
// Qualified symbol tracker: holds the last accepted W-bit symbol, the one
// before it, a change pulse and a saturating dwell counter.
// Optional: define FSM_SYM_TRACK_TRANS_CNT_EN to add the 16-bit trans_cnt
// output counting accepted changes (wraps).
module fsm_sym_track
  import fsm_sym_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int STABLE = 1,
  parameter int DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  sym_in,
  output logic [W-1:0]  state,
  output logic [W-1:0]  prev_state,
  output logic          state_vld,
  output logic          chg_pulse,
  output logic [DW-1:0] dwell,
  output logic          dwell_sat
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
  ,
  output logic [TRANS_CNT_W-1:0] trans_cnt
`endif
);

  localparam logic [DW-1:0] DWELL_MAX = {DW{1'b1}};

  logic          accept_s;
  logic [W-1:0]  acc_sym_s;
  logic [W-1:0]  state_nxt_s;
  logic [W-1:0]  prev_nxt_s;
  logic          vld_nxt_s;
  logic          chg_nxt_s;
  logic [DW-1:0] dwell_nxt_s;
  logic          sat_nxt_s;

  fsm_sym_qual #(
    .W      (W),
    .STABLE (STABLE)
  ) u_qual (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sym_in    (sym_in),
    .state     (state),
    .state_vld (state_vld),
    .accept    (accept_s),
    .acc_sym   (acc_sym_s)
  );

  // Output next-values: accept loads the symbol and restarts dwell; otherwise
  // dwell counts enabled cycles while a state is held, stopping at all-ones.
  always_comb begin
    state_nxt_s = state;
    prev_nxt_s  = prev_state;
    vld_nxt_s   = state_vld;
    chg_nxt_s   = 1'b0;
    dwell_nxt_s = dwell;

    if (accept_s) begin
      state_nxt_s = acc_sym_s;
      dwell_nxt_s = {DW{1'b0}};
      if (state_vld) begin
        prev_nxt_s = state;
        chg_nxt_s  = 1'b1;
      end else begin
        vld_nxt_s = 1'b1;
      end
    end else if (en && state_vld) begin
      if (dwell != DWELL_MAX) begin
        dwell_nxt_s = dwell + DW'(1);
      end else begin
        dwell_nxt_s = dwell;
      end
    end else begin
      dwell_nxt_s = dwell;
    end

    sat_nxt_s = (dwell_nxt_s == DWELL_MAX);
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= {W{1'b0}};
      prev_state <= {W{1'b0}};
      state_vld  <= 1'b0;
      chg_pulse  <= 1'b0;
      dwell      <= {DW{1'b0}};
      dwell_sat  <= 1'b0;
    end else begin
      state      <= state_nxt_s;
      prev_state <= prev_nxt_s;
      state_vld  <= vld_nxt_s;
      chg_pulse  <= chg_nxt_s;
      dwell      <= dwell_nxt_s;
      dwell_sat  <= sat_nxt_s;
    end
  end

`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
  // Count accepted changes (the same events that raise chg_pulse).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_cnt <= {TRANS_CNT_W{1'b0}};
    end else if (accept_s && state_vld) begin
      trans_cnt <= trans_cnt + TRANS_CNT_W'(1);
    end else begin
      trans_cnt <= trans_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fsm_sym_track.sv
// Bench for fsm_sym_track: three instances with different STABLE/DW share
// one stimulus stream; a run-length reference model predicts every output.
module tb_fsm_sym_track;

  localparam int ND = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] sym_in;

  logic [1:0]  o_st  [ND];
  logic [1:0]  o_pv  [ND];
  logic        o_vld [ND];
  logic        o_pl  [ND];
  logic        o_sat [ND];
  logic [31:0] o_dw  [ND];
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
  logic [15:0] o_tc  [ND];
`endif

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int STB = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam int DWP = (g == 0) ? 8 : (g == 1) ? 4 : 3;
    logic [1:0]     st;
    logic [1:0]     pv;
    logic           vld;
    logic           pl;
    logic           sat;
    logic [DWP-1:0] dw;
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
    logic [15:0]    tc;
`endif

    fsm_sym_track #(.W(2), .STABLE(STB), .DW(DWP)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sym_in     (sym_in),
      .state      (st),
      .prev_state (pv),
      .state_vld  (vld),
      .chg_pulse  (pl),
      .dwell      (dw),
      .dwell_sat  (sat)
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
      ,
      .trans_cnt  (tc)
`endif
    );

    assign o_st[g]  = st;
    assign o_pv[g]  = pv;
    assign o_vld[g] = vld;
    assign o_pl[g]  = pl;
    assign o_sat[g] = sat;
    assign o_dw[g]  = 32'(dw);
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
    assign o_tc[g]  = tc;
`endif
  end

  // Reference model state.
  int m_st  [ND];
  int m_pv  [ND];
  int m_vld [ND];
  int m_pl  [ND];
  int m_dw  [ND];
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
  int m_tc  [ND];
`endif
  int hist[$];   // enabled samples since reset, newest last

  int n_vec;
  int n_err;

  function automatic int stb_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction

  function automatic int dmax_of(input int d);
    return (d == 0) ? 255 : (d == 1) ? 15 : 7;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_st[d] = 0; m_pv[d] = 0; m_vld[d] = 0; m_pl[d] = 0; m_dw[d] = 0;
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
      m_tc[d] = 0;
`endif
    end
    hist.delete();
  endtask

  // A symbol is accepted when the last STABLE enabled samples all equal it
  // and it differs from the held state (or nothing is held yet).
  task automatic model_edge(input logic e, input logic [1:0] s);
    bit run_ok;
    int n;
    if (e) begin
      hist.push_back(int'(s));
      if (hist.size() > 8) void'(hist.pop_front());
    end
    for (int d = 0; d < ND; d++) begin
      m_pl[d] = 0;
      if (e) begin
        n = stb_of(d);
        run_ok = (hist.size() >= n);
        if (run_ok) begin
          for (int i = 0; i < n; i++) begin
            if (hist[hist.size() - 1 - i] != int'(s)) run_ok = 1'b0;
          end
        end
        if (run_ok && (m_vld[d] == 0 || m_st[d] != int'(s))) begin
          if (m_vld[d] != 0) begin
            m_pv[d] = m_st[d];
            m_pl[d] = 1;
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
            m_tc[d] = (m_tc[d] + 1) % 65536;
`endif
          end
          m_vld[d] = 1;
          m_st[d]  = int'(s);
          m_dw[d]  = 0;
        end else if (m_vld[d] != 0 && m_dw[d] < dmax_of(d)) begin
          m_dw[d] = m_dw[d] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("%s.d%0d.state", ph, d),      32'(o_st[d]),  m_st[d]);
      check_eq($sformatf("%s.d%0d.prev_state", ph, d), 32'(o_pv[d]),  m_pv[d]);
      check_eq($sformatf("%s.d%0d.state_vld", ph, d),  32'(o_vld[d]), m_vld[d]);
      check_eq($sformatf("%s.d%0d.chg_pulse", ph, d),  32'(o_pl[d]),  m_pl[d]);
      check_eq($sformatf("%s.d%0d.dwell", ph, d),      o_dw[d],       m_dw[d]);
      check_eq($sformatf("%s.d%0d.dwell_sat", ph, d),  32'(o_sat[d]),
               (m_dw[d] == dmax_of(d)) ? 32'd1 : 32'd0);
`ifdef FSM_SYM_TRACK_TRANS_CNT_EN
      check_eq($sformatf("%s.d%0d.trans_cnt", ph, d),  32'(o_tc[d]),  m_tc[d]);
`endif
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, check, return at
  // the next falling edge.
  task automatic step(input logic e, input logic [1:0] s);
    en     = e;
    sym_in = s;
    @(posedge clk);
    model_edge(e, s);
    #1;
    check_all("run");
    @(negedge clk);
  endtask

  // Called at a falling edge: assert reset between clock edges, confirm the
  // outputs clear without a clock, release at the next falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] s;
    logic       e;
    logic [1:0] prev_s;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b0;
    en     = 1'b0;
    sym_in = 2'b00;
    model_reset();
    @(negedge clk);
    do_reset();

    // Symbol walk: STABLE=1 follows every edge.
    step(1'b1, 2'd0); step(1'b1, 2'd1); step(1'b1, 2'd2); step(1'b1, 2'd3);
    // Settle every instance on 01.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1);
    // Short glitch that must be rejected by STABLE=3.
    step(1'b1, 2'd2); step(1'b1, 2'd2); step(1'b1, 2'd1);
    // Candidate switch then qualified change to 11.
    step(1'b1, 2'd2); step(1'b1, 2'd3); step(1'b1, 2'd3); step(1'b1, 2'd3);
    // Long hold: small dwell counters saturate.
    for (int i = 0; i < 20; i++) step(1'b1, 2'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0);
    // Enable gap in the middle of qualification.
    step(1'b1, 2'd2);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd2);
    step(1'b1, 2'd2);
    step(1'b1, 2'd2);
    // Reset in the middle of qualification.
    step(1'b1, 2'd1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0);

    // Randomised phase with sticky symbols so runs of every length occur.
    prev_s = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        e = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 9) < 6) s = prev_s;
        else s = 2'($urandom_range(0, 3));
        step(e, s);
        prev_s = s;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
